pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  ID-stage decoder and ID/EX control register for the 5-stage RV32 pipeline.
//  - Decodes RV32I (incl. LUI/AUIPC) plus optional RV32M.
//  - Registers the control bundle into EX.
//  - Detects load-use hazards and inserts bubbles.
//  - Sequences multi-cycle DIV/REM with an FSM that stalls upstream stages.
//  - Flushes the ID/EX slot on a taken branch or jump.
// PARAMETERS
//  ENABLE_M     1   1: decode RV32M (funct7=0000001); 0: those encodings are illegal
//  DIV_CYCLES   8   cycles a DIV/DIVU/REM/REMU occupies EX (>=2)
//  ALUOP_W      3   width of ex_aluop
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  id_valid     in   1        IF/ID register holds a real instruction
//  opcode       in   7        instr[6:0]
//  funct3       in   3        instr[14:12]
//  funct7       in   7        instr[31:25]
//  id_rs1       in   5        instr[19:15]
//  id_rs2       in   5        instr[24:20]
//  id_rd        in   5        instr[11:7]
//  flush        in   1        taken branch/jump resolved in EX this cycle
//  stall_id     out  1        hold PC and IF/ID (combinational)
//  ex_valid     out  1        ID/EX slot holds a real instruction
//  ex_regwrite  out  1        registered control bundle to EX (next 9 rows)
//  ex_memread   out  1
//  ex_memwrite  out  1
//  ex_memtoreg  out  1
//  ex_alusrc    out  1
//  ex_branch    out  1
//  ex_jump      out  1
//  ex_aluop     out  ALUOP_W  000 R, 001 I-ALU, 010 addr/LUI/JAL(R), 011 branch,
//                             100 AUIPC, 101 M-mul, 110 M-div
//  ex_rd        out  5        destination register of the EX instruction
//  ex_illegal   out  1        EX instruction was an undecodable encoding
//  div_busy     out  1        FSM is in DIV_RUN
// BEHAVIOUR
//  Reset: all ex_* outputs, div_busy and the cycle counter go to 0; FSM to IDLE.
//  Decode: combinational, same cycle as id_valid.
//   - R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, JAL 1101111,
//     JALR 1100111, LUI 0110111 keep their classic control values.
//   - AUIPC 0010111: regwrite=1, alusrc=1, aluop=100.
//   - M ops (opcode 0110011, funct7 0000001):
//     funct3[2]=0 -> aluop=101; funct3[2]=1 -> aluop=110.
//   - Any other opcode, or an M op with ENABLE_M=0: all enables 0, illegal=1.
//  Source use: rs1 used by R, I, L, S, B, JALR; rs2 used by R, S, B.
//  Load-use hazard:
//   - load_use = ex_valid & ex_memread & ex_rd!=0 &
//     ((ex_rd==id_rs1 & rs1 used) | (ex_rd==id_rs2 & rs2 used)).
//   - Stalls one cycle; ID/EX loads a bubble (ex_valid=0, all enables 0).
//  FSM:
//   - IDLE -> DIV_RUN on the cycle after an aluop=110 instruction is loaded
//     into ID/EX. The counter loads DIV_CYCLES-2 at that transition.
//   - DIV_RUN: the counter decrements each cycle, ID/EX holds, stall_id=1.
//   - At counter==0: return to IDLE and release the hold that cycle.
//     Total EX occupancy is exactly DIV_CYCLES cycles.
//   - Back-to-back divides re-enter DIV_RUN with no idle gap.
//  stall_id = load_use | div_busy. ID/EX update priority, highest first:
//   1. flush & !div_busy -> bubble. A flush never aborts a running divide;
//      while div_busy the ID/EX slot holds and the flush is ignored.
//   2. div_busy          -> hold.
//   3. load_use          -> bubble.
//   4. otherwise         -> load the decoded bundle, with ex_valid=id_valid.
//  id_valid=0 decodes as a bubble; it never raises ex_illegal or a hazard.
//  Async reset mid-divide: FSM to IDLE, bubble in EX, stall_id=0 immediately.
// TESTING
//  - LW x5 then ADD x6,x5,x7 -> stall_id=1 one cycle; ex_valid=0 next edge;
//    ADD enters EX the cycle after.
//  - LW x0 then ADD x6,x0,x1 -> no stall (rd==0).
//  - SW x5,0(x5) behind LW x5 -> stall; LUI x5 behind LW x5 -> no stall.
//  - DIV with DIV_CYCLES=8 -> div_busy high 7 cycles, ex_* held 8 cycles;
//    next instruction enters EX on cycle 9.
//  - ENABLE_M=0 with MUL -> ex_illegal=1, all enables 0.
//    AUIPC -> aluop=100, regwrite=1, alusrc=1.
//  - flush with a valid ADD in ID -> ex_valid=0 next edge.
//    flush during DIV_RUN -> divide completes, no bubble.
//    rst_n low mid-DIV -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// ID-stage decoder and ID/EX control register for a 5-stage RV32 pipeline.
// Decodes RV32I (+ optional RV32M), registers the control bundle into EX,
// inserts load-use bubbles, holds EX for multi-cycle divides and honours
// branch/jump flushes.
//
// Stall contract: stall_id=1 means "this cycle's ID instruction was not
// consumed"; upstream must hold PC and IF/ID so the same instruction is
// presented again next cycle. stall_id=0 means ID/EX takes the ID
// instruction (or a bubble on flush) at the next rising edge.
module pipelined_control_unit #(
  parameter int ENABLE_M   = 1,
  parameter int DIV_CYCLES = 8,
  parameter int ALUOP_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               flush,
  output logic               stall_id,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_alusrc,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [4:0]         ex_rd,
  output logic               ex_illegal,
  output logic               div_busy
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_M      = 7'b0000001;

  localparam logic [ALUOP_W-1:0] ALU_R     = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_I     = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADDR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_BR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_AUIPC = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_MUL   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_DIV   = ALUOP_W'(6);

  // Counter only ever holds values 0 .. DIV_CYCLES-2.
  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
    logic [4:0]         rd;
    logic               illegal;
  } ctrl_t;

  typedef enum logic {IDLE, DIV_RUN} state_t;

  ctrl_t      dec, ex_d, ex_q;
  logic       use_rs1, use_rs2, load_use, div_start;
  state_t     state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic       unused_funct3;

  assign unused_funct3 = ^funct3[1:0];

  // Combinational decode of the ID instruction; id_valid=0 yields a bubble.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (id_valid) begin
      dec.valid = 1'b1;
      dec.rd    = id_rd;
      case (opcode)
        OPC_R: begin
          if (funct7 == F7_M) begin
            if (ENABLE_M != 0) begin
              dec.regwrite = 1'b1;
              dec.aluop    = funct3[2] ? ALU_DIV : ALU_MUL;
              use_rs1      = 1'b1;
              use_rs2      = 1'b1;
            end else begin
              dec.illegal = 1'b1;
            end
          end else begin
            dec.regwrite = 1'b1;
            dec.aluop    = ALU_R;
            use_rs1      = 1'b1;
            use_rs2      = 1'b1;
          end
        end
        OPC_I: begin
          dec.regwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = ALU_I;
          use_rs1      = 1'b1;
        end
        OPC_L: begin
          dec.regwrite = 1'b1;
          dec.memread  = 1'b1;
          dec.memtoreg = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = ALU_ADDR;
          use_rs1      = 1'b1;
        end
        OPC_S: begin
          dec.memwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = ALU_ADDR;
          use_rs1      = 1'b1;
          use_rs2      = 1'b1;
        end
        OPC_B: begin
          dec.branch = 1'b1;
          dec.aluop  = ALU_BR;
          use_rs1    = 1'b1;
          use_rs2    = 1'b1;
        end
        OPC_JAL: begin
          dec.regwrite = 1'b1;
          dec.jump     = 1'b1;
          dec.aluop    = ALU_ADDR;
        end
        OPC_JALR: begin
          dec.regwrite = 1'b1;
          dec.jump     = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = ALU_ADDR;
          use_rs1      = 1'b1;
        end
        OPC_LUI: begin
          dec.regwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = ALU_ADDR;
        end
        OPC_AUIPC: begin
          dec.regwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = ALU_AUIPC;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign div_busy = (state == DIV_RUN);
  assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                    (((ex_q.rd == id_rs1) && use_rs1) ||
                     ((ex_q.rd == id_rs2) && use_rs2));
  assign stall_id = load_use || div_busy;

  // ID/EX next value: flush (unless dividing) > divide hold > load-use bubble > load.
  always_comb begin
    ex_d      = ex_q;
    div_start = 1'b0;
    if (flush && !div_busy) begin
      ex_d = '0;
    end else if (div_busy) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d      = dec;
      div_start = dec.valid && (dec.aluop == ALU_DIV);
    end
  end

  // ID/EX control register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Divide sequencer next state: DIV_RUN spans DIV_CYCLES-1 cycles, the
  // last EX cycle of the divide is spent back in IDLE with the hold released.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (div_start) begin
          state_d = DIV_RUN;
          cnt_d   = CNT_W'(DIV_CYCLES - 2);
        end
      end
      DIV_RUN: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Divide sequencer state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign ex_aluop    = ex_q.aluop;
  assign ex_rd       = ex_q.rd;
  assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: decode table, hand-written hazard /
// divide / flush / reset sequences, then random traffic against a model.
module tb_pipelined_control_unit;

  localparam int DIVC = 8;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] L_OP  = 7'b0000011;
  localparam logic [6:0] S_OP  = 7'b0100011;
  localparam logic [6:0] B_OP  = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  typedef struct packed {
    logic v, rw, mr, mw, m2r, as, br, j;
    logic [2:0] op;
    logic [4:0] rd;
    logic ill;
  } bundle_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bundle_t    exp;
  } vec_t;

  logic clk, rst_n, id_valid, flush;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic stall_id, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic ex_alusrc, ex_branch, ex_jump, ex_illegal, div_busy;
  logic [2:0] ex_aluop;
  logic [4:0] ex_rd;

  logic nom_stall_id, nom_ex_valid, nom_ex_regwrite, nom_ex_memread, nom_ex_memwrite;
  logic nom_ex_memtoreg, nom_ex_alusrc, nom_ex_branch, nom_ex_jump, nom_ex_illegal;
  logic nom_div_busy;
  logic [2:0] nom_ex_aluop;
  logic [4:0] nom_ex_rd;

  int checks = 0;
  int failures = 0;
  vec_t tbl[13];

  bundle_t dut_b, nom_b;
  assign dut_b = {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                  ex_alusrc, ex_branch, ex_jump, ex_aluop, ex_rd, ex_illegal};
  assign nom_b = {nom_ex_valid, nom_ex_regwrite, nom_ex_memread, nom_ex_memwrite,
                  nom_ex_memtoreg, nom_ex_alusrc, nom_ex_branch, nom_ex_jump,
                  nom_ex_aluop, nom_ex_rd, nom_ex_illegal};

  pipelined_control_unit #(.ENABLE_M(1), .DIV_CYCLES(DIVC), .ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
    .ex_illegal(ex_illegal), .div_busy(div_busy)
  );

  pipelined_control_unit #(.ENABLE_M(0), .DIV_CYCLES(DIVC), .ALUOP_W(3)) nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .flush(flush), .stall_id(nom_stall_id), .ex_valid(nom_ex_valid),
    .ex_regwrite(nom_ex_regwrite), .ex_memread(nom_ex_memread),
    .ex_memwrite(nom_ex_memwrite), .ex_memtoreg(nom_ex_memtoreg),
    .ex_alusrc(nom_ex_alusrc), .ex_branch(nom_ex_branch), .ex_jump(nom_ex_jump),
    .ex_aluop(nom_ex_aluop), .ex_rd(nom_ex_rd), .ex_illegal(nom_ex_illegal),
    .div_busy(nom_div_busy)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bundle_t ref_decode(input logic v, input logic [6:0] opc,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rd);
    bundle_t b;
    b = '0;
    if (!v) return b;
    b.v  = 1'b1;
    b.rd = rd;
    case (opc)
      R_OP:  begin b.rw = 1; b.op = (f7 == 7'b0000001) ? (f3[2] ? 3'd6 : 3'd5) : 3'd0; end
      I_OP:  begin b.rw = 1; b.as = 1; b.op = 3'd1; end
      L_OP:  begin b.rw = 1; b.mr = 1; b.m2r = 1; b.as = 1; b.op = 3'd2; end
      S_OP:  begin b.mw = 1; b.as = 1; b.op = 3'd2; end
      B_OP:  begin b.br = 1; b.op = 3'd3; end
      JAL:   begin b.rw = 1; b.j = 1; b.op = 3'd2; end
      JALR:  begin b.rw = 1; b.j = 1; b.as = 1; b.op = 3'd2; end
      LUI:   begin b.rw = 1; b.as = 1; b.op = 3'd2; end
      AUIPC: begin b.rw = 1; b.as = 1; b.op = 3'd4; end
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opc);
    return opc inside {R_OP, I_OP, L_OP, S_OP, B_OP, JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return opc inside {R_OP, S_OP, B_OP};
  endfunction

  bundle_t m_ex;
  int      m_occ;   // cycles the current EX instruction has spent in EX
  logic    m_busy, m_lu;

  assign m_busy = m_ex.v && (m_ex.op == 3'd6) && (m_occ < DIVC);
  assign m_lu   = id_valid && m_ex.v && m_ex.mr && (m_ex.rd != 5'd0) &&
                  (((m_ex.rd == id_rs1) && reads_rs1(opcode)) ||
                   ((m_ex.rd == id_rs2) && reads_rs2(opcode)));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= '0;
      m_occ <= 0;
    end else if (flush && !m_busy) begin
      m_ex  <= '0;
      m_occ <= 0;
    end else if (m_busy) begin
      m_occ <= m_occ + 1;
    end else if (m_lu) begin
      m_ex  <= '0;
      m_occ <= 0;
    end else begin
      m_ex  <= ref_decode(id_valid, opcode, funct3, funct7, id_rd);
      m_occ <= 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic fl);
    id_valid = v; opcode = opc; funct3 = f3; funct7 = f7;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble_step();
    drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
  endtask

  task automatic put(input int i, input string n, input logic [6:0] opc,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] en,
                     input logic [2:0] op, input logic ill);
    tbl[i].name = n;
    tbl[i].opc  = opc;
    tbl[i].f3   = f3;
    tbl[i].f7   = f7;
    tbl[i].exp  = {1'b1, en, op, 5'(10 + i), ill};
  endtask

  // DIV x8 then ADD x9 waiting in ID; optional flush on cycle flush_k.
  task automatic run_div(input int flush_k, input string tag);
    bubble_step();
    drive(1'b1, R_OP, 3'b100, 7'b0000001, 5'd1, 5'd2, 5'd8, 1'b0);
    step();
    drive(1'b1, R_OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd9, 1'b0);
    for (int k = 1; k <= DIVC; k++) begin
      flush = (k == flush_k);
      #1;
      chk($sformatf("%s_busy_c%0d", tag, k), 32'(div_busy), 32'(k <= DIVC - 1));
      chk($sformatf("%s_stall_c%0d", tag, k), 32'(stall_id), 32'(k <= DIVC - 1));
      chk($sformatf("%s_held_c%0d", tag, k), 32'({ex_valid, ex_aluop, ex_rd}),
          32'({1'b1, 3'd6, 5'd8}));
      step();
    end
    flush = 1'b0;
    #1;
    chk({tag, "_next_in_ex"}, 32'({ex_valid, ex_aluop, ex_rd, div_busy}),
        32'({1'b1, 3'd0, 5'd9, 1'b0}));
  endtask

  task automatic rand_drive();
    int kind;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    kind = $urandom_range(0, 12);
    f3   = 3'($urandom_range(0, 7));
    f7   = 7'd0;
    case (kind)
      0:  begin opc = R_OP; f7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'd0; end
      1:  begin opc = R_OP; f7 = 7'b0000001; f3[2] = 1'b0; end
      2:  begin opc = R_OP; f7 = 7'b0000001; f3[2] = 1'b1; end
      3:  opc = I_OP;
      4, 5: opc = L_OP;
      6:  opc = S_OP;
      7:  opc = B_OP;
      8:  opc = JAL;
      9:  opc = JALR;
      10: opc = LUI;
      11: opc = AUIPC;
      default: opc = ($urandom_range(0, 1) != 0) ? 7'h7f : 7'h0f;
    endcase
    drive(($urandom_range(0, 7) != 0), opc, f3, f7, 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // enable bits: {rw, mr, mw, m2r, as, br, j}
    put(0,  "dec_add",   R_OP,  3'd0, 7'b0000000, 7'b1000000, 3'd0, 1'b0);
    put(1,  "dec_sub",   R_OP,  3'd0, 7'b0100000, 7'b1000000, 3'd0, 1'b0);
    put(2,  "dec_addi",  I_OP,  3'd0, 7'd0,       7'b1000100, 3'd1, 1'b0);
    put(3,  "dec_lw",    L_OP,  3'd2, 7'd0,       7'b1101100, 3'd2, 1'b0);
    put(4,  "dec_sw",    S_OP,  3'd2, 7'd0,       7'b0010100, 3'd2, 1'b0);
    put(5,  "dec_beq",   B_OP,  3'd0, 7'd0,       7'b0000010, 3'd3, 1'b0);
    put(6,  "dec_jal",   JAL,   3'd0, 7'd0,       7'b1000001, 3'd2, 1'b0);
    put(7,  "dec_jalr",  JALR,  3'd0, 7'd0,       7'b1000101, 3'd2, 1'b0);
    put(8,  "dec_lui",   LUI,   3'd0, 7'd0,       7'b1000100, 3'd2, 1'b0);
    put(9,  "dec_auipc", AUIPC, 3'd0, 7'd0,       7'b1000100, 3'd4, 1'b0);
    put(10, "dec_mul",   R_OP,  3'd0, 7'b0000001, 7'b1000000, 3'd5, 1'b0);
    put(11, "dec_bad7f", 7'h7f, 3'd0, 7'd0,       7'b0000000, 3'd0, 1'b1);
    put(12, "dec_fence", 7'h0f, 3'd0, 7'd0,       7'b0000000, 3'd0, 1'b1);

    // reset state
    rst_n = 1'b0;
    drive(1'b1, R_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    #3;
    chk("reset_bundle", 32'(dut_b), 32'd0);
    chk("reset_stall", 32'(stall_id), 32'd0);
    chk("reset_busy", 32'(div_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bubble_step();

    // decode table
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].opc, tbl[i].f3, tbl[i].f7, 5'd1, 5'd2, 5'(10 + i), 1'b0);
      #1;
      chk({tbl[i].name, "_nostall"}, 32'(stall_id), 32'd0);
      step();
      #1;
      chk(tbl[i].name, 32'(dut_b), 32'(tbl[i].exp));
    end

    // LW x5 ; ADD x6,x5,x7
    bubble_step();
    drive(1'b1, L_OP, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 1'b0);
    step();
    drive(1'b1, R_OP, 3'd0, 7'd0, 5'd5, 5'd7, 5'd6, 1'b0);
    #1;
    chk("lu_stall", 32'(stall_id), 32'd1);
    step();
    #1;
    chk("lu_bubble", 32'(dut_b), 32'd0);
    chk("lu_stall_released", 32'(stall_id), 32'd0);
    step();
    #1;
    chk("lu_add_enters", 32'({ex_valid, ex_regwrite, ex_aluop, ex_rd}),
        32'({1'b1, 1'b1, 3'd0, 5'd6}));

    // LW x0 ; ADD x6,x0,x1
    drive(1'b1, L_OP, 3'd2, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, R_OP, 3'd0, 7'd0, 5'd0, 5'd1, 5'd6, 1'b0);
    #1;
    chk("lu_rd0_nostall", 32'(stall_id), 32'd0);
    step();

    // LW x5 ; SW x5,0(x5)
    drive(1'b1, L_OP, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 1'b0);
    step();
    drive(1'b1, S_OP, 3'd2, 7'd0, 5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    chk("lu_sw_stall", 32'(stall_id), 32'd1);
    step();

    // LW x5 ; LUI x5 (rs fields carry immediate bits)
    drive(1'b1, L_OP, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 1'b0);
    step();
    drive(1'b1, LUI, 3'd0, 7'd0, 5'd5, 5'd5, 5'd5, 1'b0);
    #1;
    chk("lu_lui_nostall", 32'(stall_id), 32'd0);
    step();

    // flush with a valid ADD in ID
    drive(1'b1, R_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd6, 1'b1);
    step();
    #1;
    chk("flush_bubble", 32'(dut_b), 32'd0);
    flush = 1'b0;

    // divide occupancy, plain and with a flush during the run
    run_div(0, "div");
    run_div(3, "div_flush");

    // async reset in the middle of a divide
    bubble_step();
    drive(1'b1, R_OP, 3'b101, 7'b0000001, 5'd1, 5'd2, 5'd8, 1'b0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_div_bundle", 32'(dut_b), 32'd0);
    chk("rst_mid_div_busy", 32'(div_busy), 32'd0);
    chk("rst_mid_div_stall", 32'(stall_id), 32'd0);
    drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    chk("rst_release_idle", 32'({dut_b, div_busy}), 32'd0);

    // ENABLE_M=0 instance: MUL and DIV are illegal
    drive(1'b1, R_OP, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd11, 1'b0);
    step();
    #1;
    chk("nom_mul_illegal", 32'(nom_b), 32'({1'b1, 7'd0, 3'd0, 5'd11, 1'b1}));
    chk("m_mul_aluop", 32'(ex_aluop), 32'd5);
    drive(1'b1, R_OP, 3'b100, 7'b0000001, 5'd1, 5'd2, 5'd12, 1'b0);
    step();
    #1;
    chk("nom_div_illegal", 32'(nom_b), 32'({1'b1, 7'd0, 3'd0, 5'd12, 1'b1}));
    chk("nom_div_idle", 32'({nom_div_busy, nom_stall_id}), 32'd0);
    for (int k = 0; k < DIVC + 1; k++) bubble_step();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rand_drive();
      #1;
      chk($sformatf("rnd_bundle_%0d", n), 32'(dut_b), 32'(m_ex));
      chk($sformatf("rnd_stall_%0d", n), 32'(stall_id), 32'(m_lu || m_busy));
      chk($sformatf("rnd_busy_%0d", n), 32'(div_busy), 32'(m_busy));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
